// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of a five-stage MIPS-style pipeline. It latches the
// decoded instruction and turns alu_op/funct into per-bit ALU slice controls.
// It also presents the ALU operands and store data to the EX stage.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   stall_i, flush_i        hold all state / load a bubble (flush wins)
//   id_valid_i              ID slot carries a real instruction
//   id_rs_data_i, id_rt_data_i, id_imm_i   operands and sign-extended imm
//   id_rs_i, id_rt_i, id_rd_i              register numbers
//   id_alu_op_i, id_funct_i                ALU operation selection
//   id_alu_src_i, id_reg_dst_i, id_reg_write_i, id_mem_read_i,
//   id_mem_write_i, id_mem_to_reg_i        decoded control bits
//   ex_valid_o, ex_data_a_o, ex_data_b_o, ex_store_data_o
//   ex_ctl_o, ex_binvert_o, ex_cin_o       ALU slice controls
//   ex_write_reg_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
//   ex_mem_to_reg_o, ex_illegal_o
//
// Configuration macro: FORWARD_EN
//   When defined, mem_reg_write_i/mem_rd_i/mem_result_i and
//   wb_reg_write_i/wb_rd_i/wb_result_i are present and operands A/B (and the
//   store data) are forwarded from MEM, then WB. Register 0 is never
//   forwarded.
// ---------------------------------------------------------------------------
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef FORWARD_EN
  input  logic        mem_reg_write_i,
  input  logic [4:0]  mem_rd_i,
  input  logic [31:0] mem_result_i,
  input  logic        wb_reg_write_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_result_i,
`endif
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        id_valid_i,
  input  logic [31:0] id_rs_data_i,
  input  logic [31:0] id_rt_data_i,
  input  logic [31:0] id_imm_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  id_rd_i,
  input  logic [1:0]  id_alu_op_i,
  input  logic [5:0]  id_funct_i,
  input  logic        id_alu_src_i,
  input  logic        id_reg_dst_i,
  input  logic        id_reg_write_i,
  input  logic        id_mem_read_i,
  input  logic        id_mem_write_i,
  input  logic        id_mem_to_reg_i,
  output logic        ex_valid_o,
  output logic [31:0] ex_data_a_o,
  output logic [31:0] ex_data_b_o,
  output logic [31:0] ex_store_data_o,
  output logic [2:0]  ex_ctl_o,
  output logic        ex_binvert_o,
  output logic        ex_cin_o,
  output logic [4:0]  ex_write_reg_o,
  output logic        ex_reg_write_o,
  output logic        ex_mem_read_o,
  output logic        ex_mem_write_o,
  output logic        ex_mem_to_reg_o,
  output logic        ex_illegal_o
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  // Returns {ctl[2:0], binvert, illegal}. Unknown encodings fall back to ADD
  // so the datapath always does something benign while illegal is flagged.
  function automatic logic [4:0] decode_alu(input logic [1:0] alu_op,
                                            input logic [5:0] funct);
    logic [4:0] r;
    r = {CTL_ADD, 1'b0, 1'b0};
    case (alu_op)
      2'b00: r = {CTL_ADD, 1'b0, 1'b0};
      2'b01: r = {CTL_SUB, 1'b1, 1'b0};
      2'b10: begin
        case (funct)
          6'b100000: r = {CTL_ADD, 1'b0, 1'b0};
          6'b100010: r = {CTL_SUB, 1'b1, 1'b0};
          6'b100100: r = {CTL_AND, 1'b0, 1'b0};
          6'b100101: r = {CTL_OR,  1'b0, 1'b0};
          6'b101010: r = {CTL_SLT, 1'b1, 1'b0};
          default:   r = {CTL_ADD, 1'b0, 1'b1};
        endcase
      end
      default: r = {CTL_ADD, 1'b0, 1'b1};
    endcase
    return r;
  endfunction

  logic        valid_q,      valid_d;
  logic [31:0] rs_data_q,    rs_data_d;
  logic [31:0] rt_data_q,    rt_data_d;
  logic [31:0] imm_q,        imm_d;
  logic [4:0]  write_reg_q,  write_reg_d;
  logic        alu_src_q,    alu_src_d;
  logic [2:0]  ctl_q,        ctl_d;
  logic        binvert_q,    binvert_d;
  logic        illegal_q,    illegal_d;
  logic        reg_write_q,  reg_write_d;
  logic        mem_read_q,   mem_read_d;
  logic        mem_write_q,  mem_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
`ifdef FORWARD_EN
  logic [4:0]  rs_q,         rs_d;
  logic [4:0]  rt_q,         rt_d;
`endif

  logic [4:0]  dec_s;
  logic        bubble_s;
  logic        load_s;
  logic [31:0] op_a_s;
  logic [31:0] op_b_s;

  assign dec_s    = decode_alu(id_alu_op_i, id_funct_i);
  // A load with no valid instruction behaves like a flush; flush beats stall.
  assign bubble_s = flush_i | (~stall_i & ~id_valid_i);
  assign load_s   = ~flush_i & ~stall_i & id_valid_i;

  // Next-state selection: bubble clears control only, load captures ID, else hold.
  always_comb begin
    valid_d      = valid_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    write_reg_d  = write_reg_q;
    alu_src_d    = alu_src_q;
    ctl_d        = ctl_q;
    binvert_d    = binvert_q;
    illegal_d    = illegal_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
`ifdef FORWARD_EN
    rs_d         = rs_q;
    rt_d         = rt_q;
`endif
    if (bubble_s) begin
      valid_d      = 1'b0;
      ctl_d        = CTL_ADD;
      binvert_d    = 1'b0;
      illegal_d    = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (load_s) begin
      valid_d      = 1'b1;
      rs_data_d    = id_rs_data_i;
      rt_data_d    = id_rt_data_i;
      imm_d        = id_imm_i;
      write_reg_d  = id_reg_dst_i ? id_rd_i : id_rt_i;
      alu_src_d    = id_alu_src_i;
      ctl_d        = dec_s[4:2];
      binvert_d    = dec_s[1];
      illegal_d    = dec_s[0];
      reg_write_d  = id_reg_write_i;
      mem_read_d   = id_mem_read_i;
      mem_write_d  = id_mem_write_i;
      mem_to_reg_d = id_mem_to_reg_i;
`ifdef FORWARD_EN
      rs_d         = id_rs_i;
      rt_d         = id_rt_i;
`endif
    end else begin
      valid_d      = valid_q;
    end
  end

  // Pipeline register with synchronous reset; reset overrides stall and flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      rs_data_q    <= 32'h0000_0000;
      rt_data_q    <= 32'h0000_0000;
      imm_q        <= 32'h0000_0000;
      write_reg_q  <= 5'd0;
      alu_src_q    <= 1'b0;
      ctl_q        <= CTL_ADD;
      binvert_q    <= 1'b0;
      illegal_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
`ifdef FORWARD_EN
      rs_q         <= 5'd0;
      rt_q         <= 5'd0;
`endif
    end else begin
      valid_q      <= valid_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      write_reg_q  <= write_reg_d;
      alu_src_q    <= alu_src_d;
      ctl_q        <= ctl_d;
      binvert_q    <= binvert_d;
      illegal_q    <= illegal_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
`ifdef FORWARD_EN
      rs_q         <= rs_d;
      rt_q         <= rt_d;
`endif
    end
  end

  // Operand sources: registered values, optionally overridden by MEM then WB results.
  always_comb begin
    op_a_s = rs_data_q;
    op_b_s = rt_data_q;
`ifdef FORWARD_EN
    if (mem_reg_write_i && (mem_rd_i != 5'd0) && (mem_rd_i == rs_q)) begin
      op_a_s = mem_result_i;
    end else if (wb_reg_write_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs_q)) begin
      op_a_s = wb_result_i;
    end else begin
      op_a_s = rs_data_q;
    end
    if (mem_reg_write_i && (mem_rd_i != 5'd0) && (mem_rd_i == rt_q)) begin
      op_b_s = mem_result_i;
    end else if (wb_reg_write_i && (wb_rd_i != 5'd0) && (wb_rd_i == rt_q)) begin
      op_b_s = wb_result_i;
    end else begin
      op_b_s = rt_data_q;
    end
`endif
  end

  assign ex_data_a_o     = op_a_s;
  // The immediate bypasses forwarding; store data always takes operand B.
  assign ex_data_b_o     = alu_src_q ? imm_q : op_b_s;
  assign ex_store_data_o = op_b_s;
  assign ex_valid_o      = valid_q;
  assign ex_ctl_o        = ctl_q;
  assign ex_binvert_o    = binvert_q;
  assign ex_cin_o        = binvert_q;
  assign ex_write_reg_o  = write_reg_q;
  assign ex_reg_write_o  = reg_write_q;
  assign ex_mem_read_o   = mem_read_q;
  assign ex_mem_write_o  = mem_write_q;
  assign ex_mem_to_reg_o = mem_to_reg_q;
  assign ex_illegal_o    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  typedef struct packed {
    logic        rst, stall, flush, valid;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a, b, imm;
    logic        src, dst;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  fl;   // {reg_write, mem_read, mem_write, mem_to_reg}
  } in_t;

  typedef struct packed {
    logic        v;
    logic [2:0]  ctl;
    logic        binv;
    logic [31:0] a, b, st;
    logic [4:0]  wr;
    logic [4:0]  fl;   // {reg_write, mem_read, mem_write, mem_to_reg, illegal}
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        ex_valid, ex_binvert, ex_cin, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_illegal;
  logic [31:0] ex_data_a, ex_data_b, ex_store_data;
  logic [2:0]  ex_ctl;
  logic [4:0]  ex_write_reg;
`ifdef FORWARD_EN
  logic        mem_reg_write = 1'b0, wb_reg_write = 1'b0;
  logic [4:0]  mem_rd = 5'd0, wb_rd = 5'd0;
  logic [31:0] mem_result = 32'd0, wb_result = 32'd0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst),
`ifdef FORWARD_EN
    .mem_reg_write_i(mem_reg_write), .mem_rd_i(mem_rd), .mem_result_i(mem_result),
    .wb_reg_write_i(wb_reg_write), .wb_rd_i(wb_rd), .wb_result_i(wb_result),
`endif
    .stall_i(stall), .flush_i(flush), .id_valid_i(id_valid),
    .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
    .id_alu_op_i(id_alu_op), .id_funct_i(id_funct),
    .id_alu_src_i(id_alu_src), .id_reg_dst_i(id_reg_dst), .id_reg_write_i(id_reg_write),
    .id_mem_read_i(id_mem_read), .id_mem_write_i(id_mem_write), .id_mem_to_reg_i(id_mem_to_reg),
    .ex_valid_o(ex_valid), .ex_data_a_o(ex_data_a), .ex_data_b_o(ex_data_b),
    .ex_store_data_o(ex_store_data), .ex_ctl_o(ex_ctl), .ex_binvert_o(ex_binvert),
    .ex_cin_o(ex_cin), .ex_write_reg_o(ex_write_reg), .ex_reg_write_o(ex_reg_write),
    .ex_mem_read_o(ex_mem_read), .ex_mem_write_o(ex_mem_write),
    .ex_mem_to_reg_o(ex_mem_to_reg), .ex_illegal_o(ex_illegal)
  );

  function automatic in_t mk_in(logic r, logic s, logic f, logic v, logic [1:0] op,
                                logic [5:0] fn, logic [31:0] a, logic [31:0] b,
                                logic [31:0] imm, logic src, logic dst, logic [4:0] rs,
                                logic [4:0] rt, logic [4:0] rd, logic [3:0] fl);
    in_t x;
    x.rst = r; x.stall = s; x.flush = f; x.valid = v; x.op = op; x.fn = fn;
    x.a = a; x.b = b; x.imm = imm; x.src = src; x.dst = dst;
    x.rs = rs; x.rt = rt; x.rd = rd; x.fl = fl;
    return x;
  endfunction

  function automatic exp_t mk_exp(logic v, logic [2:0] ctl, logic binv, logic [31:0] a,
                                  logic [31:0] b, logic [31:0] st, logic [4:0] wr,
                                  logic [4:0] fl);
    exp_t x;
    x.v = v; x.ctl = ctl; x.binv = binv; x.a = a; x.b = b; x.st = st; x.wr = wr; x.fl = fl;
    return x;
  endfunction

  task automatic drive(input in_t x);
    rst = x.rst; stall = x.stall; flush = x.flush; id_valid = x.valid;
    id_alu_op = x.op; id_funct = x.fn; id_rs_data = x.a; id_rt_data = x.b;
    id_imm = x.imm; id_alu_src = x.src; id_reg_dst = x.dst;
    id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = x.fl;
  endtask

  task automatic cmp(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] req);
    if (act !== req) begin
      $display("FAIL %s vec %0d: got %h, required %h", nm, idx, act, req);
      n_bad++;
    end
  endtask

  task automatic check(input int idx, input exp_t e);
    n_vec++;
    cmp("ex_valid",   idx, {31'd0, ex_valid},     {31'd0, e.v});
    cmp("ex_ctl",     idx, {29'd0, ex_ctl},       {29'd0, e.ctl});
    cmp("ex_binvert", idx, {31'd0, ex_binvert},   {31'd0, e.binv});
    cmp("ex_cin",     idx, {31'd0, ex_cin},       {31'd0, e.binv});
    cmp("ex_data_a",  idx, ex_data_a,             e.a);
    cmp("ex_data_b",  idx, ex_data_b,             e.b);
    cmp("ex_store",   idx, ex_store_data,         e.st);
    cmp("ex_wr_reg",  idx, {27'd0, ex_write_reg}, {27'd0, e.wr});
    cmp("ex_flags",   idx,
        {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal},
        {27'd0, e.fl});
  endtask

  // Behavioural reference: operation kept as a name-like index, mapped to
  // controls only when expectations are formed.
  localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_SLT = 4;
  logic [2:0] ctl_of [5];
  int          m_op;
  logic        m_valid, m_ill, m_src;
  logic [31:0] m_a, m_b, m_imm;
  logic [4:0]  m_wr;
  logic [3:0]  m_fl;

  task automatic model_step(input in_t x);
    int  op;
    logic ill;
    if (x.rst) begin
      m_valid = 1'b0; m_op = OP_ADD; m_ill = 1'b0; m_src = 1'b0;
      m_a = 32'd0; m_b = 32'd0; m_imm = 32'd0; m_wr = 5'd0; m_fl = 4'd0;
    end else if (x.flush || (!x.stall && !x.valid)) begin
      m_valid = 1'b0; m_op = OP_ADD; m_ill = 1'b0; m_fl = 4'd0;
    end else if (!x.stall) begin
      ill = 1'b0;
      op  = OP_ADD;
      if (x.op == 2'b01) op = OP_SUB;
      else if (x.op == 2'b11) ill = 1'b1;
      else if (x.op == 2'b10) begin
        if      (x.fn == 6'd32) op = OP_ADD;
        else if (x.fn == 6'd34) op = OP_SUB;
        else if (x.fn == 6'd36) op = OP_AND;
        else if (x.fn == 6'd37) op = OP_OR;
        else if (x.fn == 6'd42) op = OP_SLT;
        else ill = 1'b1;
      end
      m_valid = 1'b1; m_op = op; m_ill = ill; m_src = x.src;
      m_a = x.a; m_b = x.b; m_imm = x.imm; m_fl = x.fl;
      m_wr = x.dst ? x.rd : x.rt;
    end
  endtask

  function automatic exp_t model_exp();
    logic inv;
    inv = (m_op == OP_SUB) || (m_op == OP_SLT);
    return mk_exp(m_valid, ctl_of[m_op], inv, m_a, m_src ? m_imm : m_b, m_b, m_wr,
                  {m_fl, m_ill});
  endfunction

  vec_t tbl [19];

  initial begin
    in_t x;
    logic [5:0] legal_fn [5];
    ctl_of[0] = 3'b010; ctl_of[1] = 3'b110; ctl_of[2] = 3'b000;
    ctl_of[3] = 3'b001; ctl_of[4] = 3'b111;
    legal_fn[0] = 6'b100000; legal_fn[1] = 6'b100010; legal_fn[2] = 6'b100100;
    legal_fn[3] = 6'b100101; legal_fn[4] = 6'b101010;

    //                 rst  stl  fls  val  op     funct      rs_data       rt_data       imm           src  dst  rs    rt     rd     flags
    tbl[0]  = '{mk_in(1'b1,1'b0,1'b0,1'b1,2'b01,6'b000000,32'h1111_1111,32'h2222_2222,32'h3,       1'b1,1'b1,5'd1, 5'd2,  5'd3,  4'b1111),
                mk_exp(1'b0,3'b010,1'b0,32'd0,32'd0,32'd0,5'd0,5'b00000)};
    tbl[1]  = '{mk_in(1'b0,1'b0,1'b0,1'b1,2'b10,6'b101010,32'd5,        32'd9,        32'h1234,    1'b0,1'b1,5'd1, 5'd2,  5'd3,  4'b1000),
                mk_exp(1'b1,3'b111,1'b1,32'd5,32'd9,32'd9,5'd3,5'b10000)};
    tbl[2]  = '{mk_in(1'b0,1'b0,1'b0,1'b1,2'b00,6'b000000,32'h10,       32'h20,       32'hFFFF_FFFC,1'b1,1'b0,5'd4, 5'd5,  5'd6,  4'b1101),
                mk_exp(1'b1,3'b010,1'b0,32'h10,32'hFFFF_FFFC,32'h20,5'd5,5'b11010)};
    tbl[3]  = '{mk_in(1'b0,1'b1,1'b0,1'b1,2'b01,6'b000000,32'hAAAA,     32'hBBBB,     32'h0,       1'b0,1'b1,5'd7, 5'd8,  5'd7,  4'b0010),
                mk_exp(1'b1,3'b010,1'b0,32'h10,32'hFFFF_FFFC,32'h20,5'd5,5'b11010)};
    tbl[4]  = '{mk_in(1'b0,1'b1,1'b0,1'b0,2'b11,6'b111111,32'hCCCC,     32'hDDDD,     32'h1,       1'b0,1'b0,5'd9, 5'd10, 5'd11, 4'b0000),
                mk_exp(1'b1,3'b010,1'b0,32'h10,32'hFFFF_FFFC,32'h20,5'd5,5'b11010)};
    tbl[5]  = '{mk_in(1'b0,1'b1,1'b0,1'b1,2'b10,6'b100100,32'hEEEE,     32'hFFFF,     32'h2,       1'b0,1'b1,5'd12,5'd13, 5'd14, 4'b1111),
                mk_exp(1'b1,3'b010,1'b0,32'h10,32'hFFFF_FFFC,32'h20,5'd5,5'b11010)};
    tbl[6]  = '{mk_in(1'b0,1'b1,1'b1,1'b1,2'b01,6'b000000,32'h1,        32'h2,        32'h3,       1'b0,1'b1,5'd1, 5'd2,  5'd3,  4'b1000),
                mk_exp(1'b0,3'b010,1'b0,32'h10,32'hFFFF_FFFC,32'h20,5'd5,5'b00000)};
    tbl[7]  = '{mk_in(1'b0,1'b0,1'b0,1'b1,2'b10,6'b000111,32'd7,        32'd8,        32'h0,       1'b0,1'b0,5'd9, 5'd10, 5'd11, 4'b0010),
                mk_exp(1'b1,3'b010,1'b0,32'd7,32'd8,32'd8,5'd10,5'b00101)};
    tbl[8]  = '{mk_in(1'b0,1'b0,1'b0,1'b1,2'b11,6'b100010,32'd100,      32'd50,       32'h0,       1'b0,1'b1,5'd1, 5'd2,  5'd3,  4'b1000),
                mk_exp(1'b1,3'b010,1'b0,32'd100,32'd50,32'd50,5'd3,5'b10001)};
    tbl[9]  = '{mk_in(1'b0,1'b0,1'b0,1'b1,2'b01,6'b000000,32'd100,      32'd50,       32'h0,       1'b0,1'b0,5'd1, 5'd2,  5'd3,  4'b1000),
                mk_exp(1'b1,3'b110,1'b1,32'd100,32'd50,32'd50,5'd2,5'b10000)};
    tbl[10] = '{mk_in(1'b0,1'b0,1'b0,1'b1,2'b10,6'b100100,32'hF0F0,     32'h0FF0,     32'h0,       1'b0,1'b1,5'd1, 5'd2,  5'd31, 4'b1000),
                mk_exp(1'b1,3'b000,1'b0,32'hF0F0,32'h0FF0,32'h0FF0,5'd31,5'b10000)};
    tbl[11] = '{mk_in(1'b0,1'b0,1'b0,1'b1,2'b10,6'b100101,32'hF0F0,     32'h0FF0,     32'h0,       1'b0,1'b1,5'd1, 5'd2,  5'd31, 4'b1000),
                mk_exp(1'b1,3'b001,1'b0,32'hF0F0,32'h0FF0,32'h0FF0,5'd31,5'b10000)};
    tbl[12] = '{mk_in(1'b0,1'b0,1'b0,1'b1,2'b10,6'b100000,32'hF0F0,     32'h0FF0,     32'h0,       1'b0,1'b1,5'd1, 5'd2,  5'd31, 4'b1000),
                mk_exp(1'b1,3'b010,1'b0,32'hF0F0,32'h0FF0,32'h0FF0,5'd31,5'b10000)};
    tbl[13] = '{mk_in(1'b0,1'b0,1'b0,1'b1,2'b10,6'b100010,32'hF0F0,     32'h0FF0,     32'h0,       1'b0,1'b1,5'd1, 5'd2,  5'd31, 4'b1000),
                mk_exp(1'b1,3'b110,1'b1,32'hF0F0,32'h0FF0,32'h0FF0,5'd31,5'b10000)};
    tbl[14] = '{mk_in(1'b0,1'b0,1'b0,1'b0,2'b10,6'b101010,32'd1,        32'd2,        32'h5,       1'b1,1'b0,5'd1, 5'd2,  5'd3,  4'b1111),
                mk_exp(1'b0,3'b010,1'b0,32'hF0F0,32'h0FF0,32'h0FF0,5'd31,5'b00000)};
    tbl[15] = '{mk_in(1'b0,1'b0,1'b0,1'b1,2'b01,6'b000000,32'd3,        32'd4,        32'h0,       1'b0,1'b0,5'd1, 5'd6,  5'd7,  4'b1100),
                mk_exp(1'b1,3'b110,1'b1,32'd3,32'd4,32'd4,5'd6,5'b11000)};
    tbl[16] = '{mk_in(1'b0,1'b1,1'b0,1'b1,2'b00,6'b000000,32'd8,        32'd9,        32'h0,       1'b1,1'b1,5'd1, 5'd2,  5'd3,  4'b0011),
                mk_exp(1'b1,3'b110,1'b1,32'd3,32'd4,32'd4,5'd6,5'b11000)};
    tbl[17] = '{mk_in(1'b1,1'b1,1'b0,1'b1,2'b01,6'b000000,32'd8,        32'd9,        32'h7,       1'b1,1'b1,5'd1, 5'd2,  5'd3,  4'b1111),
                mk_exp(1'b0,3'b010,1'b0,32'd0,32'd0,32'd0,5'd0,5'b00000)};
    tbl[18] = '{mk_in(1'b0,1'b0,1'b0,1'b1,2'b00,6'b000000,32'hDEAD,     32'hBEEF,     32'h0,       1'b0,1'b1,5'd1, 5'd2,  5'd12, 4'b1000),
                mk_exp(1'b1,3'b010,1'b0,32'hDEAD,32'hBEEF,32'hBEEF,5'd12,5'b10000)};

    // Directed table: each vector is one edge, expectations visible just after it.
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      drive(tbl[k].i);
      @(posedge clk);
      #1;
      check(k, tbl[k].e);
    end

    // Randomized phase against the reference model; the first cycle resets it.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      x.rst   = (k == 0) || ($urandom_range(0, 19) == 0);
      x.flush = ($urandom_range(0, 7) == 0);
      x.stall = ($urandom_range(0, 3) == 0);
      x.valid = ($urandom_range(0, 7) != 0);
      x.op    = 2'($urandom_range(0, 3));
      x.fn    = ($urandom_range(0, 4) != 0) ? legal_fn[$urandom_range(0, 4)]
                                            : 6'($urandom_range(0, 63));
      x.a     = $urandom;
      x.b     = $urandom;
      x.imm   = $urandom;
      x.src   = 1'($urandom_range(0, 1));
      x.dst   = 1'($urandom_range(0, 1));
      x.rs    = 5'($urandom_range(0, 31));
      x.rt    = 5'($urandom_range(0, 31));
      x.rd    = 5'($urandom_range(0, 31));
      x.fl    = 4'($urandom_range(0, 15));
      drive(x);
      @(posedge clk);
      model_step(x);
      #1;
      check(100 + k, model_exp());
    end

`ifdef FORWARD_EN
    // Forwarding: rs=4, rt=0 latched, then MEM/WB results presented while stalled.
    @(negedge clk);
    drive(mk_in(1'b0,1'b0,1'b0,1'b1,2'b00,6'd0,32'h99,32'h77,32'h5,1'b0,1'b1,5'd4,5'd0,5'd1,4'b1000));
    @(posedge clk);
    #1;
    check(900, mk_exp(1'b1,3'b010,1'b0,32'h99,32'h77,32'h77,5'd1,5'b10000));
    stall = 1'b1;
    mem_reg_write = 1'b1; mem_rd = 5'd4; mem_result = 32'h11;
    wb_reg_write  = 1'b1; wb_rd  = 5'd4; wb_result  = 32'h22;
    #1;
    check(901, mk_exp(1'b1,3'b010,1'b0,32'h11,32'h77,32'h77,5'd1,5'b10000));
    mem_reg_write = 1'b0;
    #1;
    check(902, mk_exp(1'b1,3'b010,1'b0,32'h22,32'h77,32'h77,5'd1,5'b10000));
    @(negedge clk);
    mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
    drive(mk_in(1'b0,1'b0,1'b0,1'b1,2'b00,6'd0,32'h55,32'h66,32'h5,1'b0,1'b1,5'd0,5'd0,5'd1,4'b1000));
    @(posedge clk);
    #1;
    check(903, mk_exp(1'b1,3'b010,1'b0,32'h55,32'h66,32'h66,5'd1,5'b10000));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
